// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding and
// the legal operand width range.
package serial_add_sub_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN
    } state_e;

endpackage

// File: rtl/serial_add_sub_if.sv
// Operation request / result bus of the bit-serial adder/subtractor.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    // start is taken (with sub/a/b) on a rising edge only while busy=0; done
    // pulses for one cycle when s/cout/ovf have just been updated.
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, s, cout, ovf
    );

endinterface

// File: rtl/fa_cell.sv
// One-bit full adder; the only arithmetic element of serial_add_sub.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ cin_i;
    assign c_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell processes one operand bit
// per clock, LSB first, with the carry held in a register between cycles.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_add_sub_if.slave       bus,
    output logic                  dbg_state_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_add_sub: WIDTH out of range");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             cell_s;
    logic             cell_c;

    fa_cell u_fa_cell (
        .a_i   (a_q[0]),
        .b_i   (b_q[0]),
        .cin_i (carry_q),
        .s_o   (cell_s),
        .c_o   (cell_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    r_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d            = a_q >> 1;
                b_d            = b_q >> 1;
                carry_d        = cell_c;
                cnt_d          = cnt_q + 1'b1;
                r_d            = r_q >> 1;
                r_d[WIDTH-1]   = cell_s;
                if (cnt_q == LAST) begin
                    // carry_q is the carry into the MSB on this cycle.
                    s_d     = r_d;
                    cout_d  = cell_c;
                    ovf_d   = cell_c ^ carry_q;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = done_q;
    assign bus.s       = s_q;
    assign bus.cout    = cout_q;
    assign bus.ovf     = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Parametrised bit-serial adder/subtractor built around a single one-bit full-adder cell. It processes one bit per clock, LSB first, for `WIDTH` cycles, with a carry register between cycles. It trades latency for area wherever wide add/subtract throughput is not critical. A start/busy/done handshake lets a controller issue operations and collect sum, carry-out and signed overflow.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Legal range is 2 to 64.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `start` input, 1 bit: request an operation. Sampled only when `busy`=0.
- `sub` input, 1 bit: 0 selects a+b, 1 selects a−b. Sampled with `start`.
- `a` input, `WIDTH` bits: first operand. Sampled with `start`.
- `b` input, `WIDTH` bits: second operand. Sampled with `start`.
- `busy` output, 1 bit: an operation is in progress.
- `done` output, 1 bit: one-cycle pulse marking that the result outputs have just been updated.
- `s` output, `WIDTH` bits: sum or difference, modulo 2^WIDTH.
- `cout` output, 1 bit: carry out of the MSB. For subtraction it means "no borrow", i.e. a ≥ b unsigned.
- `ovf` output, 1 bit: two's-complement overflow.

## Operation
- States are IDLE and RUN.
- **IDLE, `start`=1:**
  - Load operand shift register A with `a`.
  - Load operand shift register B with `b` when `sub`=0, or `~b` when `sub`=1.
  - Load the carry register with `sub`, so subtraction is a + ~b + 1.
  - Clear the bit counter and the result shift register. Move to RUN.
- **IDLE, `start`=0:** stay in IDLE.
- **RUN, each cycle:**
  - The full-adder cell takes A[0], B[0] and the carry register.
  - The sum bit shifts into the MSB of the result register, which shifts right.
  - A and B shift right. The carry register takes the cell's carry. The counter increments.
  - Hold the carry into the MSB, i.e. the carry register value on the cycle counter = WIDTH−1.
- **RUN, last bit (counter = WIDTH−1):**
  - `s` ← final result register contents.
  - `cout` ← cell carry.
  - `ovf` ← cell carry XOR carry into the MSB.
  - `done` ← 1. Return to IDLE.
- `s`, `cout` and `ovf` change only on the completing edge. They hold their values through later operations until the next completion.
- `start` while `busy`=1 is ignored: not queued, no effect.
- `a`, `b` and `sub` may change freely after the accepting edge.

## Timing
- **Reset values:** `busy`=0, `done`=0, `s`=0, `cout`=0, `ovf`=0. State is IDLE; counter, carry and all shift registers are 0.
- **Reset mid-operation:** aborts immediately (asynchronous). No `done` pulse. The result outputs are cleared to 0.
- **Acceptance:** `start` is accepted at edge E0. `busy`=1 from just after E0.
- **Bit processing:** bits are processed at edges E1 through E_WIDTH.
- **Completion:** at edge E_WIDTH the results update, `done`=1 and `busy`=0.
- **Latency:** WIDTH cycles from the accepting edge to result valid. `done` is high for exactly one cycle.
- **Back-to-back:** `start` asserted during the `done` cycle is accepted, since `busy`=0. The maximum issue rate is one operation per WIDTH+1 cycles.
- **`busy`:** high for exactly WIDTH cycles per operation.
- **Counter width:** $clog2(WIDTH). It never reaches WIDTH, so there is no wrap-around.

## Structure
- **Sub-module `fa_cell`:** combinational one-bit full adder with inputs a, b, cin and outputs s, c. Sum is the XOR of the three inputs; carry is the majority function. It is the only arithmetic in the block and is instantiated once.
- **Shared package `serial_add_sub_pkg`:**
  - State encoding localparams ST_IDLE=1'b0 and ST_RUN=1'b1.
  - WIDTH legality bounds (2..64). An elaboration check errors if WIDTH is out of range.
- **Top level:** FSM, counter, three WIDTH-bit shift registers, the carry register and the output registers.

## Test plan
All scenarios use WIDTH=8.
- **Add with signed overflow:** `a`=0x5A, `b`=0x3C, `sub`=0 → `done` exactly 8 cycles after acceptance, `s`=0x96, `cout`=0, `ovf`=1.
- **Add with carry wrap:** `a`=0xFF, `b`=0x01, `sub`=0 → `s`=0x00, `cout`=1, `ovf`=0.
- **Subtract with borrow:** `a`=0x10, `b`=0x20, `sub`=1 → `s`=0xF0, `cout`=0, `ovf`=0. Then `a`=0x80, `b`=0x01, `sub`=1 → `s`=0x7F, `cout`=1, `ovf`=1.
- **Start while busy:** pulse `start` with `a`=0x01, `b`=0x01 at cycle 3 of a 0x5A+0x3C run → ignored. Result is 0x96 and exactly one `done` pulse.
- **Back-to-back:** assert `start` (0x01+0x02) during the `done` cycle of the previous op → accepted. `s`=0x03 after 8 more cycles, with no idle gap.
- **Reset mid-operation:** assert `rst` after bit 4 of 0xFF+0x01 → `busy`, `s`, `cout` and `ovf` are 0 immediately, no `done`. The next op 0x02+0x03 gives `s`=0x05 normally.
- **Randomised sweep:** 1000 random a/b/sub triples with a golden-model compare on s, cout and ovf.
